// File: rtl/cpu_states_pkg.sv
// Shared multicycle CPU state encoding, used by control_unit and cpu_state_sequencer.
package cpu_states_pkg;

  typedef enum logic [3:0] {
    HALT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC1  = 4'd3,
    EXEC2  = 4'd4
  } state_t;

  localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/stall_watchdog.sv
// Saturating count of consecutive stalled cycles plus a sticky bus-timeout flag.
// Only instantiated when STALL_TIMEOUT_EN is defined.
module stall_watchdog
  import cpu_states_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic timeout,
  output logic timeout_err
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES);
  localparam logic [WDOG_W-1:0] SAT   = {WDOG_W{1'b1}};

  logic [WDOG_W-1:0] cnt_reg;
  logic              err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (!stall)
        cnt_reg <= '0;
      else if (cnt_reg != SAT)
        cnt_reg <= cnt_reg + WDOG_W'(1);
      err_reg <= err_reg | timeout;
    end
  end

  // Registered count drives the forced halt on the following edge.
  assign timeout     = (cnt_reg == LIMIT);
  assign timeout_err = err_reg;

endmodule

// File: rtl/cpu_state_sequencer.sv
// Multicycle MIPS state sequencer: HALT/FETCH/DECODE/EXEC1/EXEC2 with Avalon stall hold.
// Optional bus-timeout watchdog enabled by defining STALL_TIMEOUT_EN.
module cpu_state_sequencer
  import cpu_states_pkg::*;
#(
  parameter int STATE_W        = 4,
  parameter int ICOUNT_W       = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                waitrequest,
  input  logic                memread,
  input  logic                memwrite,
  input  logic                pc_next_zero,
  output logic [STATE_W-1:0]  state,
  output logic                active,
  output logic                stall,
  output logic [ICOUNT_W-1:0] instr_count,
  output logic                timeout_err
);

  localparam logic [STATE_W-1:0] ST_HALT   = STATE_W'(HALT);
  localparam logic [STATE_W-1:0] ST_FETCH  = STATE_W'(FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE = STATE_W'(DECODE);
  localparam logic [STATE_W-1:0] ST_EXEC1  = STATE_W'(EXEC1);
  localparam logic [STATE_W-1:0] ST_EXEC2  = STATE_W'(EXEC2);

  logic [STATE_W-1:0]  state_reg, state_next;
  logic                active_reg, active_next;
  logic                launched_reg, launched_next;
  logic [ICOUNT_W-1:0] count_reg, count_next;
  logic                bus_phase;
  logic                force_halt;

  // DECODE and HALT never touch the bus, so waitrequest cannot hold them.
  assign bus_phase = (state_reg == ST_FETCH) || (state_reg == ST_EXEC1) ||
                     (state_reg == ST_EXEC2);
  assign stall     = (memread | memwrite) & waitrequest & bus_phase;

`ifdef STALL_TIMEOUT_EN
  stall_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .timeout     (force_halt),
    .timeout_err (timeout_err)
  );
`else
  assign force_halt  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    active_next   = active_reg;
    launched_next = launched_reg;
    count_next    = count_reg;
    if (force_halt) begin
      state_next    = ST_HALT;
      active_next   = 1'b0;
      launched_next = 1'b1;
    end else if (!stall) begin
      case (state_reg)
        // Only the post-reset HALT launches; a program-end HALT is terminal.
        ST_HALT: begin
          if (!launched_reg) begin
            state_next    = ST_FETCH;
            active_next   = 1'b1;
            launched_next = 1'b1;
          end
        end
        ST_FETCH:  state_next = ST_DECODE;
        ST_DECODE: state_next = ST_EXEC1;
        ST_EXEC1:  state_next = ST_EXEC2;
        ST_EXEC2: begin
          count_next = count_reg + ICOUNT_W'(1);
          if (pc_next_zero) begin
            state_next  = ST_HALT;
            active_next = 1'b0;
          end else begin
            state_next = ST_FETCH;
          end
        end
        default: begin
          state_next    = ST_HALT;
          active_next   = 1'b0;
          launched_next = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_HALT;
      active_reg   <= 1'b0;
      launched_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      active_reg   <= active_next;
      launched_reg <= launched_next;
      count_reg    <= count_next;
    end
  end

  assign state       = state_reg;
  assign active      = active_reg;
  assign instr_count = count_reg;

endmodule
